level_controller: RTL and testbench

LEVEL_CONTROLLER -- requirements
Module: level_controller

---
 rtl/level_controller.sv | 129 ++++++++++++
 tb/tb_level_controller.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/level_controller.sv
// Round controller for the whack-a-mole game: runs a timed round, raises
// difficulty from the live score and latches the score when the round ends.
module level_controller #(
    parameter int          CLK_HZ    = 50000000,
    parameter int          ROUND_SEC = 60,
    parameter int          T1        = 10,
    parameter int          T2        = 20,
    parameter int          T3        = 30,
    parameter logic [27:0] SPEED0    = 28'd50000000,
    parameter logic [27:0] SPEED1    = 28'd37500000,
    parameter logic [27:0] SPEED2    = 28'd25000000,
    parameter logic [27:0] SPEED3    = 28'd12500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  score,
    output logic        game,
    output logic [27:0] speed,
    output logic [1:0]  level,
    output logic        level_up,
    output logic [7:0]  time_left,
    output logic        game_over,
    output logic [7:0]  final_score
);

    // A one-cycle-per-second clock still needs a 1-bit prescaler to exist.
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(CLK_HZ - 1);
    localparam logic [7:0]    ROUND_LEN     = 8'(ROUND_SEC);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_reg;
    logic            start_q;
    logic [PW-1:0]   prescaler_reg;

    logic            start_edge;
    logic            tick;
    logic            final_tick;
    logic [1:0]      target;

    function automatic logic [27:0] speed_for(input logic [1:0] lvl);
        case (lvl)
            2'd0:    speed_for = SPEED0;
            2'd1:    speed_for = SPEED1;
            2'd2:    speed_for = SPEED2;
            default: speed_for = SPEED3;
        endcase
    endfunction

    // Start edge detect, one-second tick and score-derived target level.
    always_comb begin
        start_edge = start & ~start_q;
        tick       = (state_reg == PLAY) && (prescaler_reg == PRESCALE_LAST);
        // time_left <= 1 rather than == 1 so the counter can never wrap.
        final_tick = tick && (time_left <= 8'd1);
        if (score >= 8'(T3))
            target = 2'd3;
        else if (score >= 8'(T2))
            target = 2'd2;
        else if (score >= 8'(T1))
            target = 2'd1;
        else
            target = 2'd0;
    end

    // Round FSM with all outputs registered; level only ever rises in a round.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            start_q       <= 1'b0;
            prescaler_reg <= '0;
            game          <= 1'b0;
            level         <= 2'd0;
            speed         <= SPEED0;
            level_up      <= 1'b0;
            time_left     <= 8'd0;
            game_over     <= 1'b0;
            final_score   <= 8'd0;
        end else begin
            start_q  <= start;
            level_up <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (start_edge) begin
                        state_reg     <= PLAY;
                        game          <= 1'b1;
                        level         <= 2'd0;
                        speed         <= SPEED0;
                        time_left     <= ROUND_LEN;
                        prescaler_reg <= '0;
                        game_over     <= 1'b0;
                    end
                end
                PLAY: begin
                    if (tick) begin
                        prescaler_reg <= '0;
                        if (final_tick) begin
                            state_reg   <= DONE;
                            time_left   <= 8'd0;
                            game        <= 1'b0;
                            game_over   <= 1'b1;
                            final_score <= score;
                        end else begin
                            time_left <= time_left - 8'd1;
                        end
                    end else begin
                        prescaler_reg <= prescaler_reg + 1'b1;
                    end
                    // Round end wins: level and speed freeze on the final tick.
                    if (!final_tick && (target > level)) begin
                        level    <= target;
                        level_up <= 1'b1;
                        speed    <= speed_for(target);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_level_controller.sv
// Directed bench for level_controller with a 4-cycle second and 3-second round.
module tb_level_controller;

    localparam logic [27:0] S0 = 28'd50000000;
    localparam logic [27:0] S1 = 28'd37500000;
    localparam logic [27:0] S2 = 28'd25000000;
    localparam logic [27:0] S3 = 28'd12500000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  score = 8'd0;
    logic        game;
    logic [27:0] speed;
    logic [1:0]  level;
    logic        level_up;
    logic [7:0]  time_left;
    logic        game_over;
    logic [7:0]  final_score;

    int vectors = 0;
    int errors  = 0;

    level_controller #(
        .CLK_HZ(4), .ROUND_SEC(3), .T1(10), .T2(20), .T3(30),
        .SPEED0(S0), .SPEED1(S1), .SPEED2(S2), .SPEED3(S3)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .score(score),
        .game(game), .speed(speed), .level(level), .level_up(level_up),
        .time_left(time_left), .game_over(game_over), .final_score(final_score)
    );

    always #5 clock = ~clock;

    // Advance one clock edge and settle 1 time unit past it.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
        $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        // Reset state
        step(2);
        reset = 1'b0;
        chk("rst_game", {31'd0, game}, 32'd0);
        chk("rst_level", {30'd0, level}, 32'd0);
        chk("rst_speed", {4'd0, speed}, {4'd0, S0});
        chk("rst_time", {24'd0, time_left}, 32'd0);
        chk("rst_over", {31'd0, game_over}, 32'd0);
        chk("rst_final", {24'd0, final_score}, 32'd0);
        step(3);
        chk("idle_time", {24'd0, time_left}, 32'd0);
        chk("idle_game", {31'd0, game}, 32'd0);

        // Round 1: start pulse, timing, level 0->1 and monotonicity
        start = 1'b1;
        step(1);
        start = 1'b0;
        chk("r1_game", {31'd0, game}, 32'd1);
        chk("r1_time3", {24'd0, time_left}, 32'd3);
        chk("r1_speed0", {4'd0, speed}, {4'd0, S0});
        score = 8'd9;
        step(3);
        chk("r1_lvl_at9", {30'd0, level}, 32'd0);
        chk("r1_time_before", {24'd0, time_left}, 32'd3);
        step(1);
        chk("r1_time2", {24'd0, time_left}, 32'd2);
        score = 8'd10;
        step(1);
        chk("r1_lvl1", {30'd0, level}, 32'd1);
        chk("r1_lvlup", {31'd0, level_up}, 32'd1);
        chk("r1_speed1", {4'd0, speed}, {4'd0, S1});
        step(1);
        chk("r1_lvlup_off", {31'd0, level_up}, 32'd0);
        score = 8'd5;
        step(1);
        chk("r1_lvl_hold", {30'd0, level}, 32'd1);
        chk("r1_speed_hold", {4'd0, speed}, {4'd0, S1});
        start = 1'b1;                       // pulse during PLAY, lands on a tick
        step(1);
        start = 1'b0;
        chk("r1_time1", {24'd0, time_left}, 32'd1);
        chk("r1_start_ign", {31'd0, game}, 32'd1);
        step(3);
        chk("r1_pre_final", {24'd0, time_left}, 32'd1);
        score = 8'd42;
        step(1);
        chk("r1_done_game", {31'd0, game}, 32'd0);
        chk("r1_done_over", {31'd0, game_over}, 32'd1);
        chk("r1_done_time", {24'd0, time_left}, 32'd0);
        chk("r1_final42", {24'd0, final_score}, 32'd42);
        chk("r1_final_lvl", {30'd0, level}, 32'd1);
        chk("r1_final_lvlup", {31'd0, level_up}, 32'd0);
        chk("r1_final_speed", {4'd0, speed}, {4'd0, S1});
        score = 8'd45;
        step(3);
        chk("r1_hold42", {24'd0, final_score}, 32'd42);
        chk("r1_hold_lvl", {30'd0, level}, 32'd1);
        chk("r1_hold_over", {31'd0, game_over}, 32'd1);

        // Round 2: jump 0->3, start held across DONE entry
        score = 8'd0;
        start = 1'b1;
        step(1);
        chk("r2_game", {31'd0, game}, 32'd1);
        chk("r2_lvl0", {30'd0, level}, 32'd0);
        chk("r2_time3", {24'd0, time_left}, 32'd3);
        chk("r2_over0", {31'd0, game_over}, 32'd0);
        score = 8'd35;
        step(1);
        chk("r2_lvl3", {30'd0, level}, 32'd3);
        chk("r2_lvlup", {31'd0, level_up}, 32'd1);
        chk("r2_speed3", {4'd0, speed}, {4'd0, S3});
        step(1);
        chk("r2_lvlup_off", {31'd0, level_up}, 32'd0);
        step(10);
        chk("r2_done_over", {31'd0, game_over}, 32'd1);
        chk("r2_final35", {24'd0, final_score}, 32'd35);
        step(3);
        chk("r2_held_game", {31'd0, game}, 32'd0);
        chk("r2_held_over", {31'd0, game_over}, 32'd1);
        start = 1'b0;
        step(1);
        start = 1'b1;
        step(1);
        chk("r3_game", {31'd0, game}, 32'd1);
        chk("r3_lvl0", {30'd0, level}, 32'd0);
        chk("r3_time3", {24'd0, time_left}, 32'd3);
        chk("r3_speed0", {4'd0, speed}, {4'd0, S0});

        // Round 3: reach level 2 then reset mid-round
        start = 1'b0;
        score = 8'd25;
        step(1);
        chk("r3_lvl2", {30'd0, level}, 32'd2);
        chk("r3_speed2", {4'd0, speed}, {4'd0, S2});
        step(1);
        reset = 1'b1;
        start = 1'b1;
        step(1);
        chk("rst2_game", {31'd0, game}, 32'd0);
        chk("rst2_level", {30'd0, level}, 32'd0);
        chk("rst2_speed", {4'd0, speed}, {4'd0, S0});
        chk("rst2_final", {24'd0, final_score}, 32'd0);
        chk("rst2_time", {24'd0, time_left}, 32'd0);
        reset = 1'b0;
        step(1);
        chk("post_rst_start", {31'd0, game}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
